datapath_sequencer: RTL and testbench

Control sequencer that drives the 4-bit register-file/ALU datapath automatically. It replaces the manual switch and key control of register addresses, ALU op, write-data select and write enable. It fetches 16-bit instructions from an external synchronous program ROM, decodes them, and issues the same control signals the switches provide today. It also latches the ALU zero flag for conditional branches. It sits between the program ROM and the existing datapath top, and its outputs map one-to-one onto the datapath's control inputs.

---
 rtl/datapath_pkg.sv | 33 +++
 rtl/instr_decode.sv | 50 +++++
 rtl/datapath_sequencer.sv | 143 ++++++++++++++
 tb/tb_datapath_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, instruction field
// positions and the sequencer state encoding.
package datapath_pkg;

  localparam int INSTR_WIDTH = 16;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LI   = 3'b001;
  localparam logic [2:0] OP_ALU  = 3'b010;
  localparam logic [2:0] OP_BZ   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of a 16-bit instruction into its fields plus the
// per-opcode control bits used by the sequencer.
module instr_decode
  import datapath_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [2:0]             rd,
  output logic [2:0]             rs1,
  output logic [2:0]             rs2,
  output logic [3:0]             imm,
  output logic                   is_write,
  output logic                   is_alu,
  output logic                   is_branch,
  output logic                   is_cond,
  output logic                   is_halt
);

  logic [2:0] op;

  assign op  = instr[OP_MSB:OP_LSB];
  assign rd  = instr[RD_MSB:RD_LSB];
  assign rs1 = instr[RS1_MSB:RS1_LSB];
  assign rs2 = instr[RS2_MSB:RS2_LSB];
  assign imm = instr[IMM_MSB:IMM_LSB];

  // Opcodes 101 and 110 fall into the default and behave as NOP.
  always_comb begin
    is_write  = 1'b0;
    is_alu    = 1'b0;
    is_branch = 1'b0;
    is_cond   = 1'b0;
    is_halt   = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_LI:   is_write = 1'b1;
      OP_ALU: begin
        is_write = 1'b1;
        is_alu   = 1'b1;
      end
      OP_BZ: begin
        is_branch = 1'b1;
        is_cond   = 1'b1;
      end
      OP_JMP:  is_branch = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Fetch/decode/execute sequencer driving the register-file/ALU datapath from a
// synchronous program ROM; three cycles per instruction.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int PC_WIDTH       = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      start,
  output logic [PC_WIDTH-1:0]       prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  output logic [REG_ADDR_WIDTH-1:0] read_reg_1,
  output logic [REG_ADDR_WIDTH-1:0] read_reg_2,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic                      reg_write,
  output logic                      mux_sel,
  output logic [DATA_WIDTH-1:0]     imm_data,
  output logic [1:0]                alu_op,
  input  logic                      zero,
  output logic                      busy,
  output logic                      halted
);

  state_t state_reg, state_next;
  logic   restart;

  logic [PC_WIDTH-1:0]       pc_reg;
  logic                      z_flag_reg;
  logic [REG_ADDR_WIDTH-1:0] rd_reg, rs1_reg, rs2_reg;
  logic [DATA_WIDTH-1:0]     imm_reg;
  logic                      is_alu_reg, is_branch_reg, is_cond_reg, is_halt_reg;
  logic                      mux_sel_reg, reg_write_reg;

  logic [2:0] dec_rd, dec_rs1, dec_rs2;
  logic [3:0] dec_imm;
  logic       dec_is_write, dec_is_alu, dec_is_branch, dec_is_cond, dec_is_halt;

  instr_decode u_decode (
    .instr     (prog_data),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .imm       (dec_imm),
    .is_write  (dec_is_write),
    .is_alu    (dec_is_alu),
    .is_branch (dec_is_branch),
    .is_cond   (dec_is_cond),
    .is_halt   (dec_is_halt)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        busy       = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        busy       = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        busy       = 1'b1;
        state_next = is_halt_reg ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_next = S_FETCH;
          restart    = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The instruction register is held in decoded form: field registers plus
  // opcode flags, all loaded together on the edge leaving DECODE.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pc_reg        <= '0;
      z_flag_reg    <= 1'b0;
      rd_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      imm_reg       <= '0;
      is_alu_reg    <= 1'b0;
      is_branch_reg <= 1'b0;
      is_cond_reg   <= 1'b0;
      is_halt_reg   <= 1'b0;
      mux_sel_reg   <= 1'b0;
      reg_write_reg <= 1'b0;
    end else begin
      if (restart) begin
        pc_reg     <= '0;
        z_flag_reg <= 1'b0;
      end
      if (state_reg == S_DECODE) begin
        rd_reg        <= dec_rd;
        rs1_reg       <= dec_rs1;
        rs2_reg       <= dec_rs2;
        imm_reg       <= dec_imm;
        is_alu_reg    <= dec_is_alu;
        is_branch_reg <= dec_is_branch;
        is_cond_reg   <= dec_is_cond;
        is_halt_reg   <= dec_is_halt;
        mux_sel_reg   <= dec_is_write & ~dec_is_alu;
        reg_write_reg <= dec_is_write;
      end
      if (state_reg == S_EXEC) begin
        reg_write_reg <= 1'b0;
        if (is_alu_reg) z_flag_reg <= zero;
        // BZ tests the flag captured by an earlier ALU, not the live zero input.
        if (is_branch_reg && (!is_cond_reg || z_flag_reg))
          pc_reg <= imm_reg;
        else if (!is_halt_reg)
          pc_reg <= pc_reg + 1'b1;
      end
    end
  end

  assign prog_addr  = pc_reg;
  assign read_reg_1 = rs1_reg;
  assign read_reg_2 = rs2_reg;
  assign write_reg  = rd_reg;
  assign imm_data   = imm_reg;
  assign alu_op     = imm_reg[1:0];
  assign mux_sel    = mux_sel_reg;
  assign reg_write  = reg_write_reg;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: directed programs push expected
// fetch addresses and register writes; a negedge monitor pops and compares.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        zero = 1'b0;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data = '0;
  logic [2:0]  read_reg_1, read_reg_2, write_reg;
  logic        reg_write, mux_sel, busy, halted;
  logic [3:0]  imm_data;
  logic [1:0]  alu_op;

  datapath_sequencer #(.DATA_WIDTH(4), .REG_ADDR_WIDTH(3), .PC_WIDTH(4)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .read_reg_1 (read_reg_1),
    .read_reg_2 (read_reg_2),
    .write_reg  (write_reg),
    .reg_write  (reg_write),
    .mux_sel    (mux_sel),
    .imm_data   (imm_data),
    .alu_op     (alu_op),
    .zero       (zero),
    .busy       (busy),
    .halted     (halted)
  );

  always #10 clk = ~clk;

  logic [15:0] rom [16];
  always @(posedge clk) prog_data <= rom[prog_addr];

  int write_commits = 0;
  always @(posedge clk) if (reg_write) write_commits <= write_commits + 1;

  int n_vectors = 0;
  int n_miscompares = 0;

  typedef struct {
    logic [2:0] wr;
    logic       mux;
    logic [3:0] imm;
    logic [1:0] op;
    logic [2:0] r1;
    logic [2:0] r2;
  } wexp_t;

  logic [3:0] exp_fetch[$];
  wexp_t      exp_write[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vectors++;
    n_miscompares++;
    $display("FAIL %s: got %0d expected nothing", name, act);
  endtask

  function automatic wexp_t li(input logic [2:0] rd, input logic [3:0] imm);
    wexp_t w;
    w.wr = rd; w.mux = 1'b1; w.imm = imm; w.op = 2'd0; w.r1 = 3'd0; w.r2 = 3'd0;
    return w;
  endfunction

  function automatic wexp_t alu(input logic [2:0] rd, input logic [2:0] r1,
                                input logic [2:0] r2, input logic [1:0] op);
    wexp_t w;
    w.wr = rd; w.mux = 1'b0; w.imm = 4'd0; w.op = op; w.r1 = r1; w.r2 = r2;
    return w;
  endfunction

  // Monitor: FETCH is the first busy cycle and every third one after it.
  int    phase = 0;
  logic  prev_busy = 1'b0;
  logic  prev_rw = 1'b0;
  wexp_t w_got;
  always @(negedge clk) begin
    if (reset) begin
      phase = 0;
      prev_busy = 1'b0;
      prev_rw = 1'b0;
    end else begin
      if (busy) phase = prev_busy ? (phase + 1) % 3 : 0;
      if (busy && phase == 0) begin
        $display("fetch addr=%0d", prog_addr);
        if (exp_fetch.size() == 0) unexpected("fetch_extra", prog_addr);
        else check("fetch_addr", prog_addr, exp_fetch.pop_front());
      end
      if (reg_write) begin
        $display("write rd=%0d mux=%0d imm=%0d op=%0d rs1=%0d rs2=%0d",
                 write_reg, mux_sel, imm_data, alu_op, read_reg_1, read_reg_2);
        check("rw_pulse_len", prev_rw, 0);
        check("rw_in_exec", phase, 2);
        if (exp_write.size() == 0) unexpected("write_extra", write_reg);
        else begin
          w_got = exp_write.pop_front();
          check("write_reg", write_reg, w_got.wr);
          check("mux_sel", mux_sel, w_got.mux);
          if (w_got.mux) check("imm_data", imm_data, w_got.imm);
          else begin
            check("alu_op", alu_op, w_got.op);
            check("read_reg_1", read_reg_1, w_got.r1);
            check("read_reg_2", read_reg_2, w_got.r2);
          end
        end
      end
      prev_busy = busy;
      prev_rw = reg_write;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles from the edge that accepted start; optionally pokes start once.
  task automatic run_to_halt(input int poke, output int cycles);
    cycles = 1;
    while (!halted && cycles < 200) begin
      @(negedge clk);
      cycles++;
      start = (cycles == poke);
    end
    start = 1'b0;
  endtask

  task automatic check_empty(input string name);
    check(name, exp_fetch.size() + exp_write.size(), 0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int k;
    clear_rom();
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {prog_addr, read_reg_1, read_reg_2, write_reg, reg_write,
                          mux_sel, imm_data, alu_op, busy, halted}, 0);

    // LI r1,5 then HALT
    rom[0] = 16'h2405; rom[1] = 16'hE000;
    exp_fetch = {4'd0, 4'd1};
    exp_write.push_back(li(3'd1, 4'd5));
    base = write_commits;
    pulse_start();
    run_to_halt(0, cyc);
    check("t1_cycles", cyc, 7);
    check("t1_busy", busy, 0);
    check("t1_commits", write_commits - base, 1);
    check_empty("t1_left");

    // LI/LI/ALU/BZ 6 with zero=1: branch taken to HALT at 6
    do_reset();
    clear_rom();
    rom[0] = 16'h2403; rom[1] = 16'h2803; rom[2] = 16'h4CA1; rom[3] = 16'h6006;
    rom[4] = 16'h3009; rom[5] = 16'h8007; rom[6] = 16'hE000; rom[7] = 16'hE000;
    zero = 1'b1;
    exp_fetch = {4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
    exp_write.push_back(li(3'd1, 4'd3));
    exp_write.push_back(li(3'd2, 4'd3));
    exp_write.push_back(alu(3'd3, 3'd1, 3'd2, 2'd1));
    pulse_start();
    run_to_halt(0, cyc);
    check("t2_cycles", cyc, 16);
    check("t2_halted", halted, 1);
    check("t2_busy", busy, 0);
    check_empty("t2_left");

    // Same program with zero=0: falls through to 4, LI r4,9, JMP 7, HALT
    do_reset();
    zero = 1'b0;
    exp_fetch = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
    exp_write.push_back(li(3'd1, 4'd3));
    exp_write.push_back(li(3'd2, 4'd3));
    exp_write.push_back(alu(3'd3, 3'd1, 3'd2, 2'd1));
    exp_write.push_back(li(3'd4, 4'd9));
    pulse_start();
    run_to_halt(0, cyc);
    check("t3_cycles", cyc, 22);
    check("t3_halted", halted, 1);
    check_empty("t3_left");

    // All NOP: pc walks 0..15 and wraps, never writes
    do_reset();
    clear_rom();
    for (int i = 0; i < 18; i++) exp_fetch.push_back(4'(i % 16));
    base = write_commits;
    pulse_start();
    k = 0;
    while (exp_fetch.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t4_halted", halted, 0);
    check("t4_commits", write_commits - base, 0);
    check_empty("t4_left");

    // Reset during EXEC of LI r1,5: write aborted
    do_reset();
    rom[0] = 16'h2405;
    exp_fetch = {4'd0};
    exp_write.push_back(li(3'd1, 4'd5));
    pulse_start();
    k = 0;
    while (!reg_write && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_exec", reg_write, 1);
    base = write_commits;
    #1 reset = 1'b1;
    #1 check("t5_rw_async", reg_write, 0);
    check("t5_busy_async", busy, 0);
    repeat (2) @(negedge clk);
    check("t5_commits", write_commits - base, 0);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_idle", {busy, halted, prog_addr, write_reg, imm_data, mux_sel}, 0);
    check_empty("t5_left");

    // HALT then restart: pc and z_flag cleared, start ignored while busy
    do_reset();
    clear_rom();
    rom[0] = 16'h6005; rom[1] = 16'h4CA1; rom[2] = 16'hE000; rom[5] = 16'h3807;
    zero = 1'b1;
    exp_fetch = {4'd0, 4'd1, 4'd2};
    exp_write.push_back(alu(3'd3, 3'd1, 3'd2, 2'd1));
    pulse_start();
    run_to_halt(0, cyc);
    check("t6_run1_cycles", cyc, 10);
    exp_fetch = {4'd0, 4'd1, 4'd2};
    exp_write.push_back(alu(3'd3, 3'd1, 3'd2, 2'd1));
    pulse_start();
    run_to_halt(4, cyc);
    check("t6_run2_cycles", cyc, 10);
    check("t6_halted", halted, 1);
    check_empty("t6_left");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
